// File: rtl/maze_pkg.sv
// ============================================================================
// Module  : maze_pkg
// Brief   : Direction codes and tracker state encoding shared with the solver.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package maze_pkg;

    localparam logic [1:0] c_DIR_UP    = 2'd0;
    localparam logic [1:0] c_DIR_RIGHT = 2'd1;
    localparam logic [1:0] c_DIR_DOWN  = 2'd2;
    localparam logic [1:0] c_DIR_LEFT  = 2'd3;

    typedef logic [2:0] state_t;

    localparam state_t c_ST_IDLE    = 3'd0;
    localparam state_t c_ST_WAIT    = 3'd1;
    localparam state_t c_ST_REQ     = 3'd2;
    localparam state_t c_ST_TRACK   = 3'd3;
    localparam state_t c_ST_ARRIVED = 3'd4;
    localparam state_t c_ST_NOPATH  = 3'd5;
    localparam state_t c_ST_ERROR   = 3'd6;

endpackage

`default_nettype wire

// File: rtl/maze_pos_step.sv
// ============================================================================
// Module  : maze_pos_step
// Brief   : Registered rat position with one-cell step and bounds check.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module maze_pos_step
    import maze_pkg::*;
#(
    parameter int N  = 16,
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_clr,
    input  logic          i_step,
    input  logic [1:0]    i_dir,
    output logic [CW-1:0] o_row,
    output logic [CW-1:0] o_col,
    output logic [CW-1:0] o_nxt_row,
    output logic [CW-1:0] o_nxt_col,
    output logic          o_oob
);

    localparam logic [CW-1:0] c_MAX = CW'(N - 1);

    logic [CW-1:0] r_row;
    logic [CW-1:0] r_col;

    // Target cell and bounds are judged against the current position; no wrap.
    always_comb begin
        o_nxt_row = r_row;
        o_nxt_col = r_col;
        o_oob     = 1'b0;
        case (i_dir)
            c_DIR_UP: begin
                o_oob     = (r_row == '0);
                o_nxt_row = r_row - 1'b1;
            end
            c_DIR_RIGHT: begin
                o_oob     = (r_col == c_MAX);
                o_nxt_col = r_col + 1'b1;
            end
            c_DIR_DOWN: begin
                o_oob     = (r_row == c_MAX);
                o_nxt_row = r_row + 1'b1;
            end
            default: begin
                o_oob     = (r_col == '0);
                o_nxt_col = r_col - 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_row <= '0;
            r_col <= '0;
        end else if (i_step) begin
            r_row <= o_nxt_row;
            r_col <= o_nxt_col;
        end
    end

    assign o_row = r_row;
    assign o_col = r_col;

endmodule

`default_nettype wire

// File: rtl/maze_path_tracker.sv
// ============================================================================
// Module  : maze_path_tracker
// Brief   : Replay-side tracker: arms, requests replay, follows moves to goal.
//           Optional idle timeout in TRACK enabled by MAZE_TRACK_TIMEOUT_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module maze_path_tracker
    import maze_pkg::*;
#(
    parameter int N       = 16,
    parameter int CW      = 4,
    parameter int SW      = 8,
    parameter int TIMEOUT = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          done,
    input  logic          fail,
    input  logic          move,
    input  logic [1:0]    dir,
    output logic          run,
    output logic [CW-1:0] row,
    output logic [CW-1:0] col,
    output logic [SW-1:0] steps,
    output logic          busy,
    output logic          arrived,
    output logic          nopath,
    output logic          error
);

    localparam logic [CW-1:0] c_GOAL = CW'(N - 1);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [SW-1:0] r_steps;
    logic          w_arm;
    logic          w_move_acc;
    logic          w_step;
    logic          w_oob;
    logic          w_goal;
    logic          w_timeout;
    logic [CW-1:0] w_nxt_row;
    logic [CW-1:0] w_nxt_col;

    assign w_move_acc = move && ((r_state == c_ST_REQ) || (r_state == c_ST_TRACK));
    assign w_step     = w_move_acc && !w_oob;
    assign w_goal     = (w_nxt_row == c_GOAL) && (w_nxt_col == c_GOAL);
    // Any entry into WAIT from a resting state is an arm: clear position/steps.
    assign w_arm      = (w_state_nxt == c_ST_WAIT) && (r_state != c_ST_WAIT);

    maze_pos_step #(
        .N  (N),
        .CW (CW)
    ) u_pos (
        .clk       (clk),
        .rst       (rst),
        .i_clr     (w_arm),
        .i_step    (w_step),
        .i_dir     (dir),
        .o_row     (row),
        .o_col     (col),
        .o_nxt_row (w_nxt_row),
        .o_nxt_col (w_nxt_col),
        .o_oob     (w_oob)
    );

`ifdef MAZE_TRACK_TIMEOUT_EN
    logic [SW-1:0] r_idle_cnt;

    always_ff @(posedge clk) begin
        if (rst || (r_state != c_ST_TRACK) || move) begin
            r_idle_cnt <= '0;
        end else begin
            r_idle_cnt <= r_idle_cnt + 1'b1;
        end
    end

    assign w_timeout = (r_state == c_ST_TRACK) && !move && (r_idle_cnt == SW'(TIMEOUT - 1));
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT != 0);
    assign w_timeout        = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (start) w_state_nxt = c_ST_WAIT;
            end
            c_ST_WAIT: begin
                if (done && fail) w_state_nxt = c_ST_ERROR;
                else if (done)    w_state_nxt = c_ST_REQ;
                else if (fail)    w_state_nxt = c_ST_NOPATH;
                else if (move)    w_state_nxt = c_ST_ERROR;
            end
            c_ST_REQ, c_ST_TRACK: begin
                if (w_move_acc) begin
                    if (w_oob)       w_state_nxt = c_ST_ERROR;
                    else if (w_goal) w_state_nxt = c_ST_ARRIVED;
                    else             w_state_nxt = c_ST_TRACK;
                end else if (r_state == c_ST_REQ) begin
                    w_state_nxt = c_ST_TRACK;
                end else if (w_timeout) begin
                    w_state_nxt = c_ST_ERROR;
                end
            end
            c_ST_ARRIVED: begin
                if (move)       w_state_nxt = c_ST_ERROR;
                else if (start) w_state_nxt = c_ST_WAIT;
            end
            c_ST_NOPATH, c_ST_ERROR: begin
                if (start) w_state_nxt = c_ST_WAIT;
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || w_arm) begin
            r_steps <= '0;
        end else if (w_step && (r_steps != '1)) begin
            r_steps <= r_steps + 1'b1;
        end
    end

    assign steps   = r_steps;
    assign run     = (r_state == c_ST_REQ);
    assign busy    = (r_state == c_ST_WAIT) || (r_state == c_ST_REQ) || (r_state == c_ST_TRACK);
    assign arrived = (r_state == c_ST_ARRIVED);
    assign nopath  = (r_state == c_ST_NOPATH);
    assign error   = (r_state == c_ST_ERROR);

endmodule

`default_nettype wire
